// File: rtl/save_ram_uploader_if.sv
// Bundles the ioctl upload channel, the save-RAM arbitration handshake and the RAM read port.
// The master modport is the uploader; the slave modport is the HPS/arbiter/RAM environment.
interface save_ram_uploader_if #(
  parameter int ADDR_W = 10
) ();
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic              ioctl_rd;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_q;

  modport master (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, bus_gnt, mem_q,
    output ioctl_din, ioctl_wait, bus_req, mem_addr, mem_rd
  );

  modport slave (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, bus_gnt, mem_q,
    input  ioctl_din, ioctl_wait, bus_req, mem_addr, mem_rd
  );
endinterface

// File: rtl/save_ram_uploader.sv
// Serves HPS ioctl upload reads from the battery-backed save RAM, borrowing the RAM
// from the CPU through a request/grant handshake for the duration of the upload.
module save_ram_uploader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  INDEX  = 8'd4,
  parameter int          RD_LAT = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  save_ram_uploader_if.master   io,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ARMED,
    READ,
    LATCH,
    RELEASE
  } state_e;

  localparam logic [1:0] LatCnt = 2'(RD_LAT);

  state_e            state_q, state_d;
  logic              sel;
  logic              sel_prev_q;
  logic              req_q;
  logic [24:0]       req_addr_q;
  logic              accept;
  logic              pending;
  logic [24:0]       cur_addr;
  logic              pend_q, pend_d;
  logic [24:0]       addr_q, addr_d;
  logic              oor_q, oor_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              busy_q;
  logic              done_q, done_d;

  assign sel = io.ioctl_upload && (io.ioctl_index == INDEX);

  // Requests are captured one cycle before use so every output stays registered.
  assign accept   = req_q && (state_q != IDLE) && (state_q != RELEASE);
  assign pending  = pend_q || accept;
  assign cur_addr = accept ? req_addr_q : addr_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    oor_d      = oor_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    wait_d     = wait_q;
    bus_req_d  = bus_req_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    done_d     = 1'b0;

    // A second request while one is pending simply overwrites the address.
    if (accept) begin
      pend_d = 1'b1;
      addr_d = req_addr_q;
      wait_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (sel && !sel_prev_q) begin
          state_d   = REQ;
          bus_req_d = 1'b1;
        end
      end
      REQ: begin
        if (io.bus_gnt) begin
          state_d = ARMED;
        end else if (!sel) begin
          state_d = RELEASE;
        end
      end
      ARMED: begin
        if (pending) begin
          if (|cur_addr[24:ADDR_W]) begin
            oor_d   = 1'b1;
            state_d = LATCH;
          end else begin
            oor_d   = 1'b0;
            cnt_d   = 2'd0;
            state_d = READ;
          end
        end else if (!sel) begin
          state_d = RELEASE;
        end
      end
      READ: begin
        if (cnt_q == 2'd0) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q[ADDR_W-1:0];
        end
        if (cnt_q == LatCnt) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      LATCH: begin
        din_d   = oor_q ? 8'hFF : io.mem_q;
        pend_d  = 1'b0;
        wait_d  = 1'b0;
        state_d = ARMED;
      end
      RELEASE: begin
        bus_req_d = 1'b0;
        done_d    = 1'b1;
        pend_d    = 1'b0;
        wait_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_prev_q <= 1'b0;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      oor_q      <= 1'b0;
      cnt_q      <= 2'd0;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_prev_q <= sel;
      req_q      <= io.ioctl_rd && sel;
      req_addr_q <= io.ioctl_addr;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      oor_q      <= oor_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      bus_req_q  <= bus_req_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
    end
  end

  assign io.ioctl_din  = din_q;
  assign io.ioctl_wait = wait_q;
  assign io.bus_req    = bus_req_q;
  assign io.mem_addr   = mem_addr_q;
  assign io.mem_rd     = mem_rd_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_save_ram_uploader.sv
// Scoreboard bench for save_ram_uploader: expected bytes are queued when a read is issued
// and checked when ioctl_wait falls, alongside handshake and reset checks.
module tb_save_ram_uploader;
  localparam int         ADDR_W = 10;
  localparam int         RD_LAT = 2;
  localparam logic [7:0] INDEX  = 8'd4;

  typedef struct {
    logic [7:0] data;
    int         waitLen;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;
  logic done;

  save_ram_uploader_if #(.ADDR_W(ADDR_W)) sif ();

  save_ram_uploader #(
    .ADDR_W(ADDR_W),
    .INDEX (INDEX),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .io     (sif),
    .busy   (busy),
    .done   (done)
  );

  logic [7:0] ram [1024];
  logic [7:0] memPipe [RD_LAT];
  exp_t       sb[$];
  int         testsRun;
  int         failCount;
  int         memRdCount;
  int         doneCount;
  int         waitHigh;
  int         busReqHigh;
  int         waitRun;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears RD_LAT edges after the strobe and then holds.
  always @(posedge clk) begin
    if (sif.mem_rd) memPipe[0] <= ram[sif.mem_addr];
    for (int i = 1; i < RD_LAT; i++) memPipe[i] <= memPipe[i-1];
  end
  assign sif.mem_q = memPipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sif.mem_rd) memRdCount++;
    if (done) doneCount++;
    if (sif.ioctl_wait) waitHigh++;
    if (sif.bus_req) busReqHigh++;
    if (reset) begin
      waitRun = 0;
    end else if (sif.ioctl_wait) begin
      waitRun++;
    end else if (waitRun > 0) begin
      if (sb.size() == 0) begin
        checkOutput("sbUnderflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("din", sif.ioctl_din, e.data);
        if (e.waitLen >= 0) checkOutput("waitLen", waitRun, e.waitLen);
      end
      waitRun = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data,
                               input int waitLen, input bit expectResp);
    exp_t e;
    sif.ioctl_addr = addr;
    sif.ioctl_rd   = 1'b1;
    tick();
    sif.ioctl_rd   = 1'b0;
    if (expectResp) begin
      e.data    = data;
      e.waitLen = waitLen;
      sb.push_back(e);
    end
  endtask

  task automatic waitServed(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    checkOutput({tag, "Pending"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic startUpload();
    sif.ioctl_upload = 1'b1;
    sif.ioctl_index  = INDEX;
    tick();
    checkOutput("busReqRise", sif.bus_req, 32'd1);
    checkOutput("busyRise", busy, 32'd1);
  endtask

  task automatic grantAfter(input int n);
    repeat (n) tick();
    sif.bus_gnt = 1'b1;
    tick();
  endtask

  task automatic endUpload(input string tag);
    int base;
    base = doneCount;
    sif.ioctl_upload = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    repeat (2) tick();
    checkOutput({tag, "DoneOnce"}, doneCount - base, 32'd1);
    checkOutput({tag, "BusReqLow"}, sif.bus_req, 32'd0);
    checkOutput({tag, "BusyLow"}, busy, 32'd0);
    sif.bus_gnt = 1'b0;
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Din"}, sif.ioctl_din, 32'd0);
    checkOutput({tag, "Wait"}, sif.ioctl_wait, 32'd0);
    checkOutput({tag, "BusReq"}, sif.bus_req, 32'd0);
    checkOutput({tag, "MemRd"}, sif.mem_rd, 32'd0);
    checkOutput({tag, "MemAddr"}, sif.mem_addr, 32'd0);
    checkOutput({tag, "Busy"}, busy, 32'd0);
    checkOutput({tag, "Done"}, done, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int baseWait;
    int baseReq;
    int baseDone;
    testsRun   = 0;
    failCount  = 0;
    memRdCount = 0;
    doneCount  = 0;
    waitHigh   = 0;
    busReqHigh = 0;
    waitRun    = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'((i * 7) + 1);
    ram[0] = 8'h11;
    ram[1] = 8'h22;
    ram[2] = 8'h33;
    ram[3] = 8'h44;
    ram[7] = 8'h77;
    reset            = 1'b1;
    sif.ioctl_upload = 1'b0;
    sif.ioctl_index  = 8'd0;
    sif.ioctl_addr   = '0;
    sif.ioctl_rd     = 1'b0;
    sif.bus_gnt      = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    // Basic upload: grant five cycles after the request, four sequential bytes.
    startUpload();
    grantAfter(4);
    base = memRdCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(25'(i), ram[i], RD_LAT + 2, 1'b1);
      waitServed("seqRead");
    end
    checkOutput("seqMemRdCount", memRdCount - base, 32'd4);
    endUpload("seq");

    // Request held in REQ until a late grant, then out-of-range reads.
    startUpload();
    base = memRdCount;
    applyStimulus(25'd7, ram[7], -1, 1'b1);
    repeat (9) tick();
    checkOutput("waitHeldInReq", sif.ioctl_wait, 32'd1);
    checkOutput("noMemRdBeforeGnt", memRdCount - base, 32'd0);
    grantAfter(0);
    waitServed("lateGnt");
    checkOutput("lateGntMemRd", memRdCount - base, 32'd1);
    base = memRdCount;
    applyStimulus(25'h400, 8'hFF, 1, 1'b1);
    waitServed("oor400");
    applyStimulus(25'h1000003, 8'hFF, 1, 1'b1);
    waitServed("oorHigh");
    checkOutput("oorNoMemRd", memRdCount - base, 32'd0);
    endUpload("oor");

    // Upload with a foreign index must be invisible.
    sif.ioctl_upload = 1'b1;
    sif.ioctl_index  = 8'd0;
    tick();
    base     = memRdCount;
    baseWait = waitHigh;
    baseReq  = busReqHigh;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(25'(i), 8'h00, 0, 1'b0);
      repeat (3) tick();
    end
    checkOutput("foreignWait", waitHigh - baseWait, 32'd0);
    checkOutput("foreignBusReq", busReqHigh - baseReq, 32'd0);
    checkOutput("foreignMemRd", memRdCount - base, 32'd0);
    checkOutput("foreignDin", sif.ioctl_din, 32'hFF);
    checkOutput("foreignBusy", busy, 32'd0);
    sif.ioctl_upload = 1'b0;
    tick();

    // Upload ends in the very cycle the RAM strobe fires.
    startUpload();
    grantAfter(2);
    applyStimulus(25'd2, ram[2], RD_LAT + 2, 1'b1);
    tick();
    tick();
    checkOutput("memRdAtSelDrop", sif.mem_rd, 32'd1);
    checkOutput("memAddrAtSelDrop", sif.mem_addr, 32'd2);
    sif.ioctl_upload = 1'b0;
    waitServed("selDrop");
    endUpload("selDrop");

    // Reset in the middle of a read, then a fresh upload.
    startUpload();
    grantAfter(1);
    applyStimulus(25'd1, ram[1], RD_LAT + 2, 1'b1);
    tick();
    checkOutput("waitBeforeReset", sif.ioctl_wait, 32'd1);
    baseDone = doneCount;
    reset = 1'b1;
    tick();
    checkAllZero("midReset");
    tick();
    reset            = 1'b0;
    sb.delete();
    sif.bus_gnt      = 1'b0;
    sif.ioctl_upload = 1'b0;
    repeat (4) tick();
    checkOutput("resetNoDone", doneCount - baseDone, 32'd0);
    startUpload();
    grantAfter(2);
    applyStimulus(25'd3, ram[3], RD_LAT + 2, 1'b1);
    waitServed("afterReset");
    endUpload("afterReset");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
